// File: rtl/key_cond_pkg.sv
// Shared types and width helpers for the push-button conditioner.
package key_cond_pkg;

  typedef logic [1:0] hold_state_t;

  localparam hold_state_t HOLD_IDLE   = 2'd0;
  localparam hold_state_t HOLD_HELD   = 2'd1;
  localparam hold_state_t HOLD_LONG   = 2'd2;
  localparam hold_state_t HOLD_REPEAT = 2'd3;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_cond_channel.sv
// One key channel: 2-flop synchroniser, debounce counter, edge pulses and hold FSM.
module key_cond_channel
  import key_cond_pkg::*;
#(
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_key,
  input  logic i_repeat_en,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_long,
  output logic o_repeat
);

  localparam int DBW = cnt_width(DEBOUNCE_CYC);
  localparam int HCW = cnt_width(max_int(LONG_CYC, REPEAT_CYC));

  localparam logic           IDLE_PIN     = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [DBW-1:0] DB_LAST      = DBW'(DEBOUNCE_CYC - 1);
  localparam logic [HCW-1:0] HC_LONG_LAST = HCW'(LONG_CYC - 1);
  localparam logic [HCW-1:0] HC_REP_LAST  = HCW'(REPEAT_CYC - 1);

  logic           sync1_q, sync2_q;
  logic           pressed;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           level_q, level_d;
  logic           flip, press_evt, release_evt;
  hold_state_t    state_q, state_d;
  logic [HCW-1:0] hc_q, hc_d;
  logic           long_d, repeat_d;
  logic           press_q, release_q, long_q, repeat_q;

  assign pressed     = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;
  assign flip        = (pressed != level_q) && (db_cnt_q == DB_LAST);
  assign press_evt   = flip & pressed;
  assign release_evt = flip & ~pressed;

  // Any cycle where the synchronised pin agrees with the stable level restarts the count.
  always_comb begin
    db_cnt_d = '0;
    level_d  = level_q;
    if (pressed != level_q) begin
      if (db_cnt_q == DB_LAST) begin
        level_d = pressed;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    hc_d     = hc_q;
    long_d   = 1'b0;
    repeat_d = 1'b0;
    case (state_q)
      HOLD_IDLE: begin
        hc_d = '0;
        if (press_evt) state_d = HOLD_HELD;
      end
      HOLD_HELD: begin
        if (hc_q == HC_LONG_LAST) begin
          long_d  = 1'b1;
          hc_d    = '0;
          state_d = i_repeat_en ? HOLD_REPEAT : HOLD_LONG;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      HOLD_LONG: begin
        hc_d = '0;
        if (i_repeat_en) state_d = HOLD_REPEAT;
      end
      HOLD_REPEAT: begin
        if (!i_repeat_en) begin
          state_d = HOLD_LONG;
          hc_d    = '0;
        end else if (hc_q == HC_REP_LAST) begin
          repeat_d = 1'b1;
          hc_d     = '0;
        end else begin
          hc_d = hc_q + 1'b1;
        end
      end
      default: begin
        state_d = HOLD_IDLE;
        hc_d    = '0;
      end
    endcase
    // Release beats a coincident long/repeat terminal count.
    if (release_evt) begin
      state_d  = HOLD_IDLE;
      hc_d     = '0;
      long_d   = 1'b0;
      repeat_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync1_q   <= IDLE_PIN;
      sync2_q   <= IDLE_PIN;
      db_cnt_q  <= '0;
      level_q   <= 1'b0;
      state_q   <= HOLD_IDLE;
      hc_q      <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
      repeat_q  <= 1'b0;
    end else begin
      sync1_q   <= i_key;
      sync2_q   <= sync1_q;
      db_cnt_q  <= db_cnt_d;
      level_q   <= level_d;
      state_q   <= state_d;
      hc_q      <= hc_d;
      press_q   <= press_evt;
      release_q <= release_evt;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
    end
  end

  assign o_level   = level_q;
  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_repeat  = repeat_q;

endmodule

// File: rtl/key_conditioner.sv
// N-channel push-button conditioner producing single-cycle control strobes for the game core.
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int REPEAT_CYC   = 10_000_000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_key,
  input  logic [N_KEYS-1:0] i_repeat_en,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_repeat
);

  if (DEBOUNCE_CYC < 1 || LONG_CYC < 1 || REPEAT_CYC < 1) begin : g_bad_params
    $error("key_conditioner: DEBOUNCE_CYC, LONG_CYC and REPEAT_CYC must each be >= 1");
  end

  for (genvar k = 0; k < N_KEYS; k++) begin : g_chan
    key_cond_channel #(
      .ACTIVE_LOW  (ACTIVE_LOW),
      .DEBOUNCE_CYC(DEBOUNCE_CYC),
      .LONG_CYC    (LONG_CYC),
      .REPEAT_CYC  (REPEAT_CYC)
    ) u_chan (
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
      .i_key      (i_key[k]),
      .i_repeat_en(i_repeat_en[k]),
      .o_level    (o_level[k]),
      .o_press    (o_press[k]),
      .o_release  (o_release[k]),
      .o_long     (o_long[k]),
      .o_repeat   (o_repeat[k])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Scoreboard bench: expected pulse events are queued with stimulus and popped as the DUT pulses.
`timescale 1ns/1ps
module tb_key_conditioner;

  localparam int NK     = 2;
  localparam int K_PRESS = 0;
  localparam int K_REL   = 1;
  localparam int K_LONG  = 2;
  localparam int K_REP   = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NK-1:0] key = 2'b11;
  logic [NK-1:0] ren = 2'b00;
  logic [NK-1:0] level, press, rel, lng, rep;
  logic [7:0]    pulses;

  typedef struct {
    int cyc;
    int ch;
    int kind;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  key_conditioner #(
    .N_KEYS      (NK),
    .ACTIVE_LOW  (1),
    .DEBOUNCE_CYC(4),
    .LONG_CYC    (10),
    .REPEAT_CYC  (3)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_key      (key),
    .i_repeat_en(ren),
    .o_level    (level),
    .o_press    (press),
    .o_release  (rel),
    .o_long     (lng),
    .o_repeat   (rep)
  );

  // Bit kind*2+ch
  assign pulses = {rep, lng, rel, press};

  always @(negedge clk) begin
    for (int ch = 0; ch < NK; ch++) begin
      for (int k = 0; k < 4; k++) begin
        if (pulses[k*2+ch] === 1'b1) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL event: got kind=%0d ch=%0d at cycle %0d, required no event", k, ch, cyc);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc !== cyc || e.ch !== ch || e.kind !== k) begin
              n_fail++;
              $display("FAIL event: got kind=%0d ch=%0d cyc=%0d, required kind=%0d ch=%0d cyc=%0d",
                       k, ch, cyc, e.kind, e.ch, e.cyc);
            end
          end
        end
      end
    end
  end

  task automatic push(input int c, input int ch, input int kind);
    exp_q.push_back('{cyc: c, ch: ch, kind: kind});
  endtask

  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sync_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int t0;
    rst_n = 1'b0;
    key   = 2'b11;
    ren   = 2'b00;
    for (int i = 0; i < 20; i++) begin
      sync_edge();
      n_cmp++;
      if ({level, press, rel, lng, rep} !== 10'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b required 0", {level, press, rel, lng, rep});
      end
    end
    rst_n = 1'b1;
    t0 = cyc;
    wait_edge(t0 + 20);
    n_cmp++;
    if (level !== 2'b00) begin
      n_fail++;
      $display("FAIL post_reset_level: got %b required 00", level);
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_pending: got %0d queued required 0", exp_q.size());
    end
  endtask

  task automatic test_press_release();
    int t0;
    sync_edge();
    t0 = cyc;
    key[0] = 1'b0;
    push(t0 + 6, 0, K_PRESS);
    push(t0 + 14, 0, K_REL);
    wait_edge(t0 + 5);
    n_cmp++;
    if (level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL level_early: got %b required 0", level[0]);
    end
    wait_edge(t0 + 6);
    n_cmp++;
    if (level[0] !== 1'b1 || press[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL press_edge: got level=%b press=%b required 1 1", level[0], press[0]);
    end
    wait_edge(t0 + 7);
    n_cmp++;
    if (press[0] !== 1'b0 || level[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL press_width: got press=%b level=%b required 0 1", press[0], level[0]);
    end
    wait_edge(t0 + 8);
    key[0] = 1'b1;
    wait_edge(t0 + 14);
    n_cmp++;
    if (level[0] !== 1'b0 || rel[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL release_edge: got level=%b release=%b required 0 1", level[0], rel[0]);
    end
    wait_edge(t0 + 24);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL press_release_pending: got %0d queued required 0", exp_q.size());
    end
  endtask

  task automatic test_bounce();
    int t, tf;
    sync_edge();
    t  = cyc;
    tf = t + 8;
    push(tf + 6, 0, K_PRESS);
    push(tf + 14, 0, K_REL);
    key[0] = 1'b0;
    wait_edge(t + 3);
    key[0] = 1'b1;
    wait_edge(t + 4);
    key[0] = 1'b0;
    wait_edge(t + 7);
    key[0] = 1'b1;
    wait_edge(tf);
    key[0] = 1'b0;
    wait_edge(tf + 5);
    n_cmp++;
    if (level[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL bounce_level: got %b required 0", level[0]);
    end
    wait_edge(tf + 8);
    key[0] = 1'b1;
    wait_edge(tf + 24);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL bounce_pending: got %0d queued required 0", exp_q.size());
    end
  endtask

  task automatic test_long();
    int p;
    ren = 2'b00;
    sync_edge();
    p = cyc + 6;
    key[0] = 1'b0;
    push(p, 0, K_PRESS);
    push(p + 10, 0, K_LONG);
    push(p + 31, 0, K_REL);
    wait_edge(p + 9);
    n_cmp++;
    if (lng[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL long_early: got %b required 0", lng[0]);
    end
    wait_edge(p + 10);
    n_cmp++;
    if (lng[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL long_edge: got %b required 1", lng[0]);
    end
    wait_edge(p + 25);
    key[0] = 1'b1;
    wait_edge(p + 40);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL long_pending: got %0d queued required 0", exp_q.size());
    end
  endtask

  task automatic test_repeat();
    int p, l;
    ren = 2'b01;
    sync_edge();
    p = cyc + 6;
    l = p + 10;
    key[0] = 1'b0;
    push(p, 0, K_PRESS);
    push(l, 0, K_LONG);
    push(l + 3, 0, K_REP);
    push(l + 6, 0, K_REP);
    push(l + 9, 0, K_REP);
    push(l + 12, 0, K_REP);
    push(l + 15, 0, K_REL);
    wait_edge(l + 9);
    key[0] = 1'b1;
    wait_edge(l + 15);
    n_cmp++;
    if (rel[0] !== 1'b1 || rep[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_wins: got release=%b repeat=%b required 1 0", rel[0], rep[0]);
    end
    wait_edge(l + 30);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL repeat_pending: got %0d queued required 0", exp_q.size());
    end
    ren = 2'b00;
  endtask

  task automatic test_repeat_toggle();
    int p;
    ren = 2'b00;
    sync_edge();
    p = cyc + 6;
    key[1] = 1'b0;
    push(p, 1, K_PRESS);
    push(p + 10, 1, K_LONG);
    push(p + 18, 1, K_REP);
    push(p + 21, 1, K_REP);
    push(p + 32, 1, K_REL);
    wait_edge(p + 14);
    ren[1] = 1'b1;
    wait_edge(p + 22);
    ren[1] = 1'b0;
    wait_edge(p + 23);
    n_cmp++;
    if (rep[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL disable_no_pulse: got %b required 0", rep[1]);
    end
    wait_edge(p + 26);
    key[1] = 1'b1;
    wait_edge(p + 42);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL toggle_pending: got %0d queued required 0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid();
    int t0, r;
    ren = 2'b11;
    sync_edge();
    t0 = cyc;
    key[0] = 1'b0;
    push(t0 + 6, 0, K_PRESS);
    push(t0 + 8, 1, K_PRESS);
    push(t0 + 16, 0, K_LONG);
    push(t0 + 18, 1, K_LONG);
    push(t0 + 19, 0, K_REP);
    push(t0 + 21, 1, K_REP);
    push(t0 + 22, 0, K_REP);
    wait_edge(t0 + 2);
    key[1] = 1'b0;
    wait_edge(t0 + 23);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({level, press, rel, lng, rep} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %b required 0", {level, press, rel, lng, rep});
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_pending: got %0d queued required 0", exp_q.size());
    end
    wait_edge(t0 + 28);
    rst_n = 1'b1;
    r = cyc;
    push(r + 6, 0, K_PRESS);
    push(r + 6, 1, K_PRESS);
    push(r + 14, 0, K_REL);
    push(r + 14, 1, K_REL);
    wait_edge(r + 5);
    n_cmp++;
    if (level !== 2'b00) begin
      n_fail++;
      $display("FAIL rereport_early: got level=%b required 00", level);
    end
    wait_edge(r + 6);
    n_cmp++;
    if (press !== 2'b11) begin
      n_fail++;
      $display("FAIL rereport_press: got %b required 11", press);
    end
    wait_edge(r + 8);
    key = 2'b11;
    wait_edge(r + 24);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL rereport_pending: got %0d queued required 0", exp_q.size());
    end
    ren = 2'b00;
  endtask

  initial begin
    test_reset();
    test_press_release();
    test_bounce();
    test_long();
    test_repeat();
    test_repeat_toggle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
